writeback_unit: RTL

Writeback arbiter and load scoreboard feeding the single write port of the 32×32 register bank. Merges single-cycle ALU results with buffered load returns from the LSU, drives one registered write per cycle into the register bank, and tracks registers with outstanding loads so the decode stage can stall on RAW/WAW hazards.

---
 rtl/writeback_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback arbiter plus load scoreboard driving the register bank's single write port.
// Optional macro WB_INFLIGHT_HAZARD_EN also stalls on the write currently presented to the bank.
module writeback_unit #(
    parameter int LSU_FIFO_DEPTH = 2,
    localparam int ADDR_WIDTH = 5,
    localparam int WORD_WIDTH = 32,
    localparam int CW = $clog2(LSU_FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [WORD_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [WORD_WIDTH-1:0] lsu_data_i,
    input  logic                  issue_load_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  hazard_o,
    output logic [ADDR_WIDTH-1:0] write_addr_o,
    output logic [WORD_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic [CW-1:0]         fifo_count_o
);
    localparam int PW = $clog2(LSU_FIFO_DEPTH);
    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] addr_mem [LSU_FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] data_mem [LSU_FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop;

    logic                  write_en_q, write_en_d;
    logic                  is_load_q, is_load_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [WORD_WIDTH-1:0] write_data_q, write_data_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  inflight_hazard;

    assign lsu_ready_o = (count_q < CW'(LSU_FIFO_DEPTH));

    // Pop decision uses the registered count, so a push into an empty FIFO waits a cycle.
    always_comb begin
        push     = lsu_valid_i && lsu_ready_o;
        pop      = !alu_valid_i && (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        write_en_d   = 1'b0;
        is_load_d    = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (alu_valid_i) begin
            write_addr_d = alu_addr_i;
            write_data_d = alu_data_i;
            write_en_d   = (alu_addr_i != '0);
        end else if (pop) begin
            write_addr_d = addr_mem[rd_ptr_q];
            write_data_d = data_mem[rd_ptr_q];
            write_en_d   = (addr_mem[rd_ptr_q] != '0);
            is_load_d    = 1'b1;
        end
    end

    // Clear first, then set, so a re-issue of the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (write_en_q && is_load_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (issue_load_i) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= lsu_addr_i;
            data_mem[wr_ptr_q] <= lsu_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            is_load_q    <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            is_load_q    <= is_load_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

`ifdef WB_INFLIGHT_HAZARD_EN
    assign inflight_hazard = write_en_q && (write_addr_q != '0) &&
                             ((write_addr_q == rs1_addr_i) || (write_addr_q == rs2_addr_i));
`else
    assign inflight_hazard = 1'b0;
`endif

    assign hazard_o     = busy_q[rs1_addr_i] | busy_q[rs2_addr_i] | busy_q[rd_addr_i] | inflight_hazard;
    assign write_en_o   = write_en_q;
    assign write_addr_o = write_addr_q;
    assign write_data_o = write_data_q;
    assign fifo_count_o = count_q;

endmodule
